// File: rtl/my_pe_pkg.sv
// Shared types and constants for the fp32 dot-product PE sequencer.
package my_pe_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_FETCH_B = 3'd2,
        S_LOAD    = 3'd3,
        S_ISSUE0  = 3'd4,
        S_WAIT    = 3'd5,
        S_DONE    = 3'd6
    } ctrl_state_t;

    localparam logic [31:0] FP32_ZERO       = 32'h0000_0000;
    localparam int          MIN_FMA_LATENCY = 4;

endpackage

// File: rtl/my_pe_ctrl.sv
// Sequencer feeding one fp32 FMA PE through an N-element dot product.
// Optional cycle counter output enabled by MY_PE_CTRL_CYCLE_CNT_EN.
module my_pe_ctrl
    import my_pe_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int VECTOR_SIZE = 16,
    parameter int ADDR_WIDTH  = 6,
    parameter int FMA_LATENCY = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rddata,
    output logic [DATA_WIDTH-1:0] pe_ain,
    output logic [DATA_WIDTH-1:0] pe_bin,
    output logic                  pe_valid,
    input  logic                  pe_dvalid,
    input  logic [DATA_WIDTH-1:0] pe_dout
`ifdef MY_PE_CTRL_CYCLE_CNT_EN
    ,
    output logic [31:0]           cycles
`endif
);

    localparam int IDX_W = $clog2(VECTOR_SIZE + 1);
    localparam logic [IDX_W-1:0]      N_IDX  = IDX_W'(VECTOR_SIZE);
    localparam logic [ADDR_WIDTH-1:0] B_BASE = ADDR_WIDTH'(VECTOR_SIZE);

    if (FMA_LATENCY < MIN_FMA_LATENCY) begin : g_lat_chk
        $error("FMA_LATENCY below MIN_FMA_LATENCY");
    end

    ctrl_state_t           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  op_ready_q, op_ready_d;
    logic [DATA_WIDTH-1:0] a_stage_q, a_stage_d;
    logic [DATA_WIDTH-1:0] pe_ain_q, pe_ain_d;
    logic [DATA_WIDTH-1:0] pe_bin_q, pe_bin_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  mem_en_c;
    logic [ADDR_WIDTH-1:0] mem_addr_c;
    logic                  pe_valid_c;
    logic [IDX_W-1:0]      idx_inc;

    assign idx_inc = idx_q + IDX_W'(1);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            op_ready_q <= 1'b0;
            a_stage_q  <= FP32_ZERO;
            pe_ain_q   <= FP32_ZERO;
            pe_bin_q   <= FP32_ZERO;
            result_q   <= FP32_ZERO;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            op_ready_q <= op_ready_d;
            a_stage_q  <= a_stage_d;
            pe_ain_q   <= pe_ain_d;
            pe_bin_q   <= pe_bin_d;
            result_q   <= result_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        op_ready_d = op_ready_q;
        a_stage_d  = a_stage_q;
        pe_ain_d   = pe_ain_q;
        pe_bin_d   = pe_bin_q;
        result_d   = result_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mem_en_c   = 1'b0;
        mem_addr_c = '0;
        pe_valid_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH_A;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_FETCH_A: begin
                mem_en_c   = 1'b1;
                mem_addr_c = ADDR_WIDTH'(idx_q);
                state_d    = S_FETCH_B;
            end
            S_FETCH_B: begin
                mem_en_c   = 1'b1;
                mem_addr_c = B_BASE + ADDR_WIDTH'(idx_q);
                a_stage_d  = mem_rddata;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                pe_ain_d   = a_stage_q;
                pe_bin_d   = mem_rddata;
                op_ready_d = 1'b1;
                state_d    = (idx_q == '0) ? S_ISSUE0 : S_WAIT;
            end
            S_ISSUE0: begin
                pe_valid_c = 1'b1;
                op_ready_d = 1'b0;
                idx_d      = idx_inc;
                state_d    = (idx_inc < N_IDX) ? S_FETCH_A : S_WAIT;
            end
            S_WAIT: begin
                // Issue only on the dvalid cycle so the PE sees its own
                // running sum on the accumulator input.
                if (pe_dvalid) begin
                    if (idx_q < N_IDX) begin
                        if (op_ready_q) begin
                            pe_valid_c = 1'b1;
                            op_ready_d = 1'b0;
                            idx_d      = idx_inc;
                            if (idx_inc < N_IDX) begin
                                state_d = S_FETCH_A;
                            end
                        end
                    end else begin
                        result_d = pe_dout;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign mem_en   = mem_en_c;
    assign mem_addr = mem_addr_c;
    assign pe_ain   = pe_ain_q;
    assign pe_bin   = pe_bin_q;
    assign pe_valid = pe_valid_c;

`ifdef MY_PE_CTRL_CYCLE_CNT_EN
    logic [31:0] cycles_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cycles_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            cycles_q <= '0;
        end else if (busy_q && cycles_q != 32'hFFFF_FFFF) begin
            cycles_q <= cycles_q + 32'd1;
        end
    end

    assign cycles = cycles_q;
`endif

endmodule
